calc_core: RTL

CALC_CORE -- requirements
Module: calc_core

---
 rtl/calc_core.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/calc_core.sv
// Hex keypad calculator core: two-operand entry, ADD/SUB in one cycle,
// MUL by iterative shift-add over WIDTH cycles, with sticky overflow.
module calc_core #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             newkey,
  input  logic [4:0]       keycode,
  output logic [WIDTH-1:0] display,
  output logic             busy,
  output logic             overflow,
  output logic             key_dropped
);

  localparam int DIGITS = WIDTH / 4;
  localparam int CW     = $clog2(DIGITS + 1);
  localparam int EW     = $clog2(WIDTH);

  localparam logic [2:0] ENTRY_A = 3'd0;
  localparam logic [2:0] OP_PEND = 3'd1;
  localparam logic [2:0] ENTRY_B = 3'd2;
  localparam logic [2:0] EXEC    = 3'd3;
  localparam logic [2:0] RESULT  = 3'd4;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  logic [2:0]         state;
  logic [WIDTH-1:0]   a, b, result, disp_hold;
  logic [WIDTH-1:0]   opa, opb, mplier;
  logic [2*WIDTH-1:0] mcand, prod;
  logic [CW-1:0]      count;
  logic [EW-1:0]      cycle;
  logic [1:0]         op, next_op;
  logic               chain;

  logic               is_digit, is_op, is_eq, is_ce, is_ac;
  logic [WIDTH-1:0]   digit_val;
  logic               start_exec, start_chain;
  logic [WIDTH-1:0]   start_a;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_next;
  logic               last;
  logic [WIDTH-1:0]   exec_val;
  logic               exec_ovf;

  // Classify the incoming key and zero-extend a digit to operand width.
  always_comb begin
    is_digit  = keycode[4];
    is_op     = !keycode[4] && (keycode[3:0] <= 4'h2);
    is_eq     = (keycode == 5'h03);
    is_ce     = (keycode == 5'h04);
    is_ac     = (keycode == 5'h05);
    digit_val = {{(WIDTH-4){1'b0}}, keycode[3:0]};
  end

  // Decide when a keypress launches an operation and which value acts as A.
  always_comb begin
    start_exec  = 1'b0;
    start_chain = 1'b0;
    start_a     = a;
    if (newkey && state == ENTRY_B && (is_eq || is_op)) begin
      start_exec  = 1'b1;
      start_chain = is_op;
    end
    if (newkey && state == RESULT && is_eq) begin
      start_exec = 1'b1;
      start_a    = result;
    end
  end

  // Arithmetic datapath; the multiply folds in its final partial product
  // combinationally so the result lands on the last EXEC cycle.
  always_comb begin
    sum       = {1'b0, opa} + {1'b0, opb};
    prod_next = prod + (mplier[0] ? mcand : '0);
    last      = (op != OP_MUL) || (cycle == EW'(WIDTH - 1));
    exec_val  = sum[WIDTH-1:0];
    exec_ovf  = sum[WIDTH];
    case (op)
      OP_SUB: begin
        exec_val = opa - opb;
        exec_ovf = (opa < opb);
      end
      OP_MUL: begin
        exec_val = prod_next[WIDTH-1:0];
        exec_ovf = |prod_next[2*WIDTH-1:WIDTH];
      end
      default: ;
    endcase
  end

  // Select what the display shows; EXEC holds the value seen before launch.
  always_comb begin
    case (state)
      ENTRY_B: display = b;
      EXEC:    display = disp_hold;
      RESULT:  display = result;
      default: display = a;
    endcase
    busy = (state == EXEC);
  end

  // Main keypad state machine; AC behaves exactly like reset, even mid-EXEC.
  always_ff @(posedge clock) begin
    if (reset || (newkey && is_ac)) begin
      state       <= ENTRY_A;
      a           <= '0;
      b           <= '0;
      result      <= '0;
      disp_hold   <= '0;
      opa         <= '0;
      opb         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      prod        <= '0;
      count       <= '0;
      cycle       <= '0;
      op          <= OP_ADD;
      next_op     <= OP_ADD;
      chain       <= 1'b0;
      overflow    <= 1'b0;
      key_dropped <= 1'b0;
    end else begin
      key_dropped <= 1'b0;
      if (start_exec) begin
        state     <= EXEC;
        opa       <= start_a;
        opb       <= b;
        mcand     <= {{WIDTH{1'b0}}, start_a};
        mplier    <= b;
        prod      <= '0;
        cycle     <= '0;
        overflow  <= 1'b0;
        disp_hold <= display;
        chain     <= start_chain;
        if (start_chain) next_op <= keycode[1:0];
      end else begin
        case (state)
          ENTRY_A: if (newkey) begin
            if (is_digit && count < CW'(DIGITS)) begin
              a     <= {a[WIDTH-5:0], keycode[3:0]};
              count <= count + CW'(1);
            end else if (is_op) begin
              op    <= keycode[1:0];
              state <= OP_PEND;
            end else if (is_ce) begin
              a     <= '0;
              count <= '0;
            end
          end
          OP_PEND: if (newkey) begin
            if (is_op) begin
              op <= keycode[1:0];
            end else if (is_digit) begin
              b     <= digit_val;
              count <= CW'(1);
              state <= ENTRY_B;
            end
          end
          ENTRY_B: if (newkey) begin
            if (is_digit && count < CW'(DIGITS)) begin
              b     <= {b[WIDTH-5:0], keycode[3:0]};
              count <= count + CW'(1);
            end else if (is_ce) begin
              b     <= '0;
              count <= '0;
            end
          end
          EXEC: begin
            if (newkey && (is_digit || is_op || is_eq || is_ce))
              key_dropped <= 1'b1;
            prod   <= prod_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cycle  <= cycle + EW'(1);
            if (last) begin
              result   <= exec_val;
              overflow <= exec_ovf;
              if (chain) begin
                a     <= exec_val;
                op    <= next_op;
                count <= '0;
                state <= OP_PEND;
              end else begin
                state <= RESULT;
              end
            end
          end
          RESULT: if (newkey) begin
            if (is_digit) begin
              a     <= digit_val;
              count <= CW'(1);
              state <= ENTRY_A;
            end else if (is_op) begin
              a     <= result;
              op    <= keycode[1:0];
              count <= '0;
              state <= OP_PEND;
            end
          end
          default: state <= ENTRY_A;
        endcase
      end
    end
  end

endmodule
